// File: rtl/reg_file_dump_reader_if.sv
// -----------------------------------------------------------------------------
// reg_file_dump_reader_if
// Bundles the control, register-file read-port and stream signals of the
// register file dump reader.
//   master : the dump reader (drives read address, stream word, status)
//   slave  : the environment (register file, stream consumer, controller)
// Signals:
//   start_i / abort_i          dump request / cancel
//   rd_addr_o / rd_data_i      register file read port (combinational data)
//   dump_data_o, dump_index_o, dump_valid_o, dump_ready_i, dump_last_o
//                              valid/ready word stream
//   busy_o / done_o            status
// -----------------------------------------------------------------------------
interface reg_file_dump_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic                  abort_i;
  logic [4:0]            rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic [DATA_WIDTH-1:0] dump_data_o;
  logic [4:0]            dump_index_o;
  logic                  dump_valid_o;
  logic                  dump_ready_i;
  logic                  dump_last_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  start_i, abort_i, rd_data_i, dump_ready_i,
    output rd_addr_o, dump_data_o, dump_index_o, dump_valid_o,
    output dump_last_o, busy_o, done_o
  );

  modport slave (
    output start_i, abort_i, rd_data_i, dump_ready_i,
    input  rd_addr_o, dump_data_o, dump_index_o, dump_valid_o,
    input  dump_last_o, busy_o, done_o
  );
endinterface

// File: rtl/reg_file_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_file_dump_reader
// Walks register indices FIRST_REG..LAST_REG through a spare register file
// read port and streams each value over a valid/ready interface. Never writes
// the register file.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high reset
//   bus    : reg_file_dump_reader_if.master (start/abort, read port, stream,
//            busy/done status)
// Optional feature (macro REG_DUMP_CHECKSUM_EN): an XOR checksum of all
// accepted register words is appended as one extra word carrying
// dump_index_o = LAST_REG and dump_last_o = 1.
// Each word takes two cycles: READ presents the address and captures the
// combinational read data, SEND holds the word until the handshake.
// -----------------------------------------------------------------------------
module reg_file_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31
) (
  input logic                    clk,
  input logic                    reset,
  reg_file_dump_reader_if.master bus
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE, S_SUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

  state_t                state;
  logic [4:0]            idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  is_last;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc;
`endif

  assign is_last         = (idx == LAST_IDX);
  // data_q is the presented stream word; it also carries the checksum word
  assign bus.dump_data_o = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      idx              <= '0;
      data_q           <= '0;
      bus.rd_addr_o    <= '0;
      bus.dump_index_o <= '0;
      bus.dump_valid_o <= 1'b0;
      bus.dump_last_o  <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc              <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            idx           <= FIRST_IDX;
            bus.rd_addr_o <= FIRST_IDX;
            bus.busy_o    <= 1'b1;
            state         <= S_READ;
`ifdef REG_DUMP_CHECKSUM_EN
            acc           <= '0;
`endif
          end
        end

        S_READ: begin
          if (bus.abort_i) begin
            bus.rd_addr_o <= '0;
            bus.busy_o    <= 1'b0;
            state         <= S_IDLE;
          end else begin
            data_q           <= bus.rd_data_i;
            bus.dump_index_o <= idx;
            bus.dump_valid_o <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            bus.dump_last_o  <= 1'b0;
`else
            bus.dump_last_o  <= is_last;
`endif
            state            <= S_SEND;
          end
        end

        S_SEND: begin
          // abort outranks a same-cycle handshake
          if (bus.abort_i) begin
            bus.dump_valid_o <= 1'b0;
            bus.dump_last_o  <= 1'b0;
            bus.rd_addr_o    <= '0;
            bus.busy_o       <= 1'b0;
            state            <= S_IDLE;
          end else if (bus.dump_ready_i) begin
            if (is_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
              // checksum word reuses the LAST_REG index
              acc             <= acc ^ data_q;
              data_q          <= acc ^ data_q;
              bus.dump_last_o <= 1'b1;
              state           <= S_SUM;
`else
              bus.dump_valid_o <= 1'b0;
              bus.dump_last_o  <= 1'b0;
              bus.rd_addr_o    <= '0;
              bus.done_o       <= 1'b1;
              state            <= S_DONE;
`endif
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              acc              <= acc ^ data_q;
`endif
              idx              <= idx + 5'd1;
              bus.rd_addr_o    <= idx + 5'd1;
              bus.dump_valid_o <= 1'b0;
              bus.dump_last_o  <= 1'b0;
              state            <= S_READ;
            end
          end
        end

`ifdef REG_DUMP_CHECKSUM_EN
        S_SUM: begin
          if (bus.abort_i) begin
            bus.dump_valid_o <= 1'b0;
            bus.dump_last_o  <= 1'b0;
            bus.rd_addr_o    <= '0;
            bus.busy_o       <= 1'b0;
            state            <= S_IDLE;
          end else if (bus.dump_ready_i) begin
            bus.dump_valid_o <= 1'b0;
            bus.dump_last_o  <= 1'b0;
            bus.rd_addr_o    <= '0;
            bus.done_o       <= 1'b1;
            state            <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          bus.done_o <= 1'b0;
          bus.busy_o <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
